// File: rtl/keylock_core.sv
// keylock_core: keypad code entry, user/master code check, user code
// reprogramming with confirmation, and a failed-attempt lockout timer.
module keylock_core #(
  parameter int unsigned         DIGITS         = 6,
  parameter logic [4*DIGITS-1:0] PC             = 24'h555116,
  parameter logic [4*DIGITS-1:0] UC_INIT        = 24'h666666,
  parameter int unsigned         MAX_FAILS      = 3,
  parameter int unsigned         LOCKOUT_CYCLES = 24000000,
  localparam int unsigned        CW             = $clog2(DIGITS + 1),
  localparam int unsigned        FW             = $clog2(MAX_FAILS + 1)
) (
  input  logic          hwclk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [3:0]    key,
  output logic          locked,
  output logic          lockout,
  output logic          prog_mode,
  output logic          ok_pulse,
  output logic          err_pulse,
  output logic          uc_changed,
  output logic [CW-1:0] digit_count,
  output logic [FW-1:0] fail_count
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NEW_UC,
    S_CHECK_NEW,
    S_CONFIRM_UC,
    S_CHECK_CONF,
    S_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [BW-1:0] uc_q, uc_d;
  logic [BW-1:0] cand_q, cand_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lk_cnt_q, lk_cnt_d;
  logic          locked_q, locked_d;
  logic          lockout_q, lockout_d;
  logic          prog_q, prog_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          ucc_q, ucc_d;

  logic          entry_ok;
  logic          is_digit;
  logic          is_clear;
  logic          is_enter;
  logic          bad_attempt;
  logic [FW-1:0] fail_inc;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    uc_d        = uc_q;
    cand_d      = cand_q;
    fail_d      = fail_q;
    lk_cnt_d    = lk_cnt_q;
    locked_d    = locked_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    ucc_d       = 1'b0;
    bad_attempt = 1'b0;

    entry_ok = (cnt_q == CW'(DIGITS)) && !ovf_q;
    is_digit = key_valid && (key <= 4'd9);
    is_clear = key_valid && (key == 4'd10);
    is_enter = key_valid && (key == 4'd11);
    fail_inc = fail_q + FW'(1);

    case (state_q)
      S_IDLE, S_NEW_UC, S_CONFIRM_UC: begin
        if (is_digit) begin
          if (cnt_q < CW'(DIGITS)) begin
            buf_d = (buf_q << 4) | BW'(key);
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_clear) begin
          buf_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (is_enter) begin
          case (state_q)
            S_NEW_UC:     state_d = S_CHECK_NEW;
            S_CONFIRM_UC: state_d = S_CHECK_CONF;
            default:      state_d = S_CHECK;
          endcase
        end
      end

      S_CHECK: begin
        buf_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
        if (!entry_ok) begin
          bad_attempt = 1'b1;
        end else if (buf_q == PC) begin
          state_d = S_NEW_UC;
          fail_d  = '0;
        end else if (buf_q == uc_q) begin
          locked_d = !locked_q;
          ok_d     = 1'b1;
          fail_d   = '0;
        end else begin
          bad_attempt = 1'b1;
        end
        if (bad_attempt) begin
          err_d  = 1'b1;
          fail_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d  = S_LOCKOUT;
            lk_cnt_d = LW'(LOCKOUT_CYCLES - 1);
          end
        end
      end

      S_CHECK_NEW: begin
        buf_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        if (entry_ok && (buf_q != PC)) begin
          cand_d  = buf_q;
          state_d = S_CONFIRM_UC;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_CHECK_CONF: begin
        buf_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
        if (entry_ok && (buf_q == cand_q)) begin
          uc_d  = cand_q;
          ucc_d = 1'b1;
          ok_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (lk_cnt_q == '0) begin
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lk_cnt_d = lk_cnt_q - LW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    lockout_d = (state_d == S_LOCKOUT);
    prog_d    = (state_d inside {S_NEW_UC, S_CHECK_NEW, S_CONFIRM_UC, S_CHECK_CONF});
  end

  // State and output registers
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      uc_q      <= UC_INIT;
      cand_q    <= '0;
      fail_q    <= '0;
      lk_cnt_q  <= '0;
      locked_q  <= 1'b0;
      lockout_q <= 1'b0;
      prog_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      ucc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      uc_q      <= uc_d;
      cand_q    <= cand_d;
      fail_q    <= fail_d;
      lk_cnt_q  <= lk_cnt_d;
      locked_q  <= locked_d;
      lockout_q <= lockout_d;
      prog_q    <= prog_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      ucc_q     <= ucc_d;
    end
  end

  assign locked      = locked_q;
  assign lockout     = lockout_q;
  assign prog_mode   = prog_q;
  assign ok_pulse    = ok_q;
  assign err_pulse   = err_q;
  assign uc_changed  = ucc_q;
  assign digit_count = cnt_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_keylock_core.sv
// tb_keylock_core: vector table, corner-case sequences and randomized
// transactions against a code-level reference model.
module tb_keylock_core;

  localparam logic [23:0] PC6 = 24'h555116;
  localparam int unsigned LCY = 50;

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid4 = 1'b0;
  logic [3:0] key4 = 4'd0;

  logic       locked, lockout, prog_mode, ok_pulse, err_pulse, uc_changed;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic       locked4, lockout4, prog_mode4, ok_pulse4, err_pulse4, uc_changed4;
  logic [2:0] digit_count4;
  logic [1:0] fail_count4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 hwclk = ~hwclk;

  keylock_core #(
    .DIGITS(6), .PC(24'h555116), .UC_INIT(24'h666666),
    .MAX_FAILS(3), .LOCKOUT_CYCLES(LCY)
  ) u_dut (
    .hwclk(hwclk), .reset(reset), .key_valid(key_valid), .key(key),
    .locked(locked), .lockout(lockout), .prog_mode(prog_mode),
    .ok_pulse(ok_pulse), .err_pulse(err_pulse), .uc_changed(uc_changed),
    .digit_count(digit_count), .fail_count(fail_count)
  );

  keylock_core #(
    .DIGITS(4), .PC(16'h1234), .UC_INIT(16'h0000),
    .MAX_FAILS(3), .LOCKOUT_CYCLES(LCY)
  ) u_dut4 (
    .hwclk(hwclk), .reset(reset), .key_valid(key_valid4), .key(key4),
    .locked(locked4), .lockout(lockout4), .prog_mode(prog_mode4),
    .ok_pulse(ok_pulse4), .err_pulse(err_pulse4), .uc_changed(uc_changed4),
    .digit_count(digit_count4), .fail_count(fail_count4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All stimulus tasks start and end on a falling edge
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key       = k;
    @(negedge hwclk);
    key_valid = 1'b0;
    key       = 4'd0;
  endtask

  task automatic press4(input logic [3:0] k);
    key_valid4 = 1'b1;
    key4       = k;
    @(negedge hwclk);
    key_valid4 = 1'b0;
    key4       = 4'd0;
  endtask

  task automatic enter_code(input logic [63:0] seq, input int len);
    logic [63:0] s;
    s = seq;
    for (int j = 0; j < len; j++) press(s[4*(len-1-j) +: 4]);
  endtask

  task automatic do_code(input logic [63:0] seq, input int len);
    enter_code(seq, len);
    press(4'd11);
    @(negedge hwclk);
    @(negedge hwclk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
  endtask

  // Counts lockout-high cycles; optionally strobes the valid user code mid-lockout
  task automatic wait_lockout(input bit inject_uc, output int n);
    n = 0;
    while (lockout === 1'b1 && n < 200) begin
      n++;
      if (inject_uc) begin
        key_valid = (n >= 10 && n < 17);
        key       = (n == 16) ? 4'd11 : 4'd6;
      end else begin
        key_valid = 1'($urandom_range(0, 1));
        key       = 4'($urandom_range(0, 15));
      end
      @(negedge hwclk);
    end
    key_valid = 1'b0;
    key       = 4'd0;
  endtask

  // ---------------- reference model (code-level) ----------------
  int          m_digits[$];
  bit          m_ovf;
  logic [23:0] m_uc, m_cand;
  bit          m_locked, m_lockout;
  int          m_fails, m_mode;   // mode: 0 normal, 1 new code, 2 confirm

  function automatic logic [23:0] m_value();
    logic [23:0] v;
    v = '0;
    foreach (m_digits[i]) v = v * 24'd16 + 24'(m_digits[i]);
    return v;
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_digits.size() < 6) m_digits.push_back(k);
      else m_ovf = 1'b1;
    end else if (k == 10) begin
      m_digits.delete();
      m_ovf = 1'b0;
    end
  endtask

  task automatic model_enter(output bit e_ok, output bit e_err, output bit e_ucc);
    bit          valid;
    logic [23:0] v;
    valid = (m_digits.size() == 6) && !m_ovf;
    v     = m_value();
    e_ok  = 1'b0;
    e_err = 1'b0;
    e_ucc = 1'b0;
    if (m_mode == 0) begin
      if (valid && v == PC6) begin
        m_mode  = 1;
        m_fails = 0;
      end else if (valid && v == m_uc) begin
        m_locked = !m_locked;
        e_ok     = 1'b1;
        m_fails  = 0;
      end else begin
        e_err = 1'b1;
        m_fails++;
        if (m_fails == 3) m_lockout = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (valid && v != PC6) begin
        m_cand = v;
        m_mode = 2;
      end else begin
        e_err  = 1'b1;
        m_mode = 0;
      end
    end else begin
      if (valid && v == m_cand) begin
        m_uc  = m_cand;
        e_ok  = 1'b1;
        e_ucc = 1'b1;
      end else begin
        e_err = 1'b1;
      end
      m_mode = 0;
    end
    m_digits.delete();
    m_ovf = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] seq;
    int          len;
    int          e_cnt;
    bit          e_ok, e_err, e_ucc, e_locked, e_prog;
    int          e_fail;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit eo, ee, eu;

    //               seq                len cnt ok err ucc lck prg fail
    vecs[0]  = '{64'h666666,       6, 6, 1, 0, 0, 1, 0, 0};
    vecs[1]  = '{64'h666666,       6, 6, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{64'h666,          3, 3, 0, 1, 0, 0, 0, 1};
    vecs[3]  = '{64'h6666666,      7, 6, 0, 1, 0, 0, 0, 2};
    vecs[4]  = '{64'h12A666666,    9, 6, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{64'h6C6F6666,     8, 6, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{64'h555116,       6, 6, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{64'h123456,       6, 6, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{64'h123456,       6, 6, 1, 0, 1, 0, 0, 0};
    vecs[9]  = '{64'h666666,       6, 6, 0, 1, 0, 0, 0, 1};
    vecs[10] = '{64'h123456,       6, 6, 1, 0, 0, 1, 0, 0};
    vecs[11] = '{64'h555116,       6, 6, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{64'h111111,       6, 6, 0, 0, 0, 1, 1, 0};
    vecs[13] = '{64'h222222,       6, 6, 0, 1, 0, 1, 0, 0};
    vecs[14] = '{64'h999999,       6, 6, 0, 1, 0, 1, 0, 1};
    vecs[15] = '{64'h555116,       6, 6, 0, 0, 0, 1, 1, 0};
    vecs[16] = '{64'h555116,       6, 6, 0, 1, 0, 1, 0, 0};
    vecs[17] = '{64'h123456,       6, 6, 1, 0, 0, 0, 0, 0};
    vecs[18] = '{64'h555116,       6, 6, 0, 0, 0, 0, 1, 0};
    vecs[19] = '{64'h12,           2, 2, 0, 1, 0, 0, 0, 0};

    // Reset state
    @(negedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
    chk("rst_locked", locked, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_prog", prog_mode, 0);
    chk("rst_ok", ok_pulse, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_ucc", uc_changed, 0);
    chk("rst_cnt", digit_count, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst4_outs", {locked4, lockout4, prog_mode4, ok_pulse4, err_pulse4,
                      uc_changed4, digit_count4, fail_count4}, 0);

    // Table-driven transactions, state carried from one row to the next
    for (int i = 0; i < NV; i++) begin
      enter_code(vecs[i].seq, vecs[i].len);
      chk($sformatf("vec%0d_cnt", i), digit_count, vecs[i].e_cnt);
      press(4'd11);
      @(negedge hwclk);
      chk($sformatf("vec%0d_ok", i), ok_pulse, vecs[i].e_ok);
      chk($sformatf("vec%0d_err", i), err_pulse, vecs[i].e_err);
      chk($sformatf("vec%0d_ucc", i), uc_changed, vecs[i].e_ucc);
      chk($sformatf("vec%0d_locked", i), locked, vecs[i].e_locked);
      chk($sformatf("vec%0d_prog", i), prog_mode, vecs[i].e_prog);
      chk($sformatf("vec%0d_fail", i), fail_count, vecs[i].e_fail);
      chk($sformatf("vec%0d_cntclr", i), digit_count, 0);
      @(negedge hwclk);
      chk($sformatf("vec%0d_pulse_end", i), {ok_pulse, err_pulse, uc_changed}, 0);
    end

    // A digit strobed while the check is in progress is dropped
    do_reset();
    enter_code(64'h666666, 6);
    press(4'd11);
    press(4'd6);
    chk("drop_ok", ok_pulse, 1);
    chk("drop_locked", locked, 1);
    chk("drop_cnt", digit_count, 0);
    @(negedge hwclk);

    // Reset mid-confirmation restores UC_INIT and clears everything at once
    do_reset();
    do_code(64'h555116, 6);
    do_code(64'h123456, 6);
    do_code(64'h123456, 6);
    do_code(64'h555116, 6);
    do_code(64'h777777, 6);
    chk("rstmid_prog_before", prog_mode, 1);
    press(4'd7);
    press(4'd7);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_prog", prog_mode, 0);
    chk("rstmid_cnt", digit_count, 0);
    chk("rstmid_outs", {locked, lockout, ok_pulse, err_pulse, uc_changed, fail_count}, 0);
    @(negedge hwclk);
    reset = 1'b0;
    enter_code(64'h666666, 6);
    press(4'd11);
    @(negedge hwclk);
    chk("rstmid_uc_init_ok", ok_pulse, 1);
    chk("rstmid_uc_init_locked", locked, 1);
    @(negedge hwclk);

    // Three failures: exact lockout length, keys refused, first key after accepted
    do_reset();
    do_code(64'h111111, 6);
    do_code(64'h222222, 6);
    chk("lk_fail2", fail_count, 2);
    enter_code(64'h333333, 6);
    press(4'd11);
    @(negedge hwclk);
    chk("lk_enter", lockout, 1);
    chk("lk_err", err_pulse, 1);
    chk("lk_fail3", fail_count, 3);
    wait_lockout(1'b1, n);
    chk("lk_len", n, LCY);
    chk("lk_fail_clr", fail_count, 0);
    chk("lk_locked_kept", locked, 0);
    chk("lk_cnt", digit_count, 0);
    enter_code(64'h666666, 6);
    chk("lk_first_key_cnt", digit_count, 6);
    press(4'd11);
    @(negedge hwclk);
    chk("lk_after_unlock", locked, 1);
    @(negedge hwclk);

    // Four-digit instance
    press4(4'd0); press4(4'd0); press4(4'd0); press4(4'd0);
    chk("d4_cnt", digit_count4, 4);
    press4(4'd11);
    @(negedge hwclk);
    chk("d4_ok", ok_pulse4, 1);
    chk("d4_locked", locked4, 1);
    @(negedge hwclk);
    press4(4'd1); press4(4'd2); press4(4'd3); press4(4'd4); press4(4'd11);
    @(negedge hwclk);
    chk("d4_prog", prog_mode4, 1);
    @(negedge hwclk);

    // Randomized transactions against the reference model
    do_reset();
    m_digits.delete();
    m_ovf = 0; m_uc = 24'h666666; m_cand = '0;
    m_locked = 0; m_lockout = 0; m_fails = 0; m_mode = 0;
    for (int t = 0; t < 150; t++) begin
      int ks[$];
      int ty;
      int len;
      int k;
      ty = $urandom_range(0, 4);
      case (ty)
        0: for (int i = 5; i >= 0; i--) ks.push_back(int'((m_uc >> (4*i)) & 24'hF));
        1: for (int i = 5; i >= 0; i--) ks.push_back(int'((PC6 >> (4*i)) & 24'hF));
        2: for (int i = 5; i >= 0; i--) ks.push_back(int'((m_cand >> (4*i)) & 24'hF));
        3: begin
          len = $urandom_range(0, 8);
          for (int i = 0; i < len; i++) ks.push_back($urandom_range(0, 9));
        end
        default: begin
          len = $urandom_range(0, 9);
          for (int i = 0; i < len; i++) begin
            k = $urandom_range(0, 14);
            if (k >= 11) k++;
            ks.push_back(k);
          end
        end
      endcase
      foreach (ks[j]) begin
        press(4'(ks[j]));
        model_key(ks[j]);
        chk("rnd_cnt", digit_count, m_digits.size());
      end
      press(4'd11);
      model_enter(eo, ee, eu);
      @(negedge hwclk);
      chk("rnd_ok", ok_pulse, eo);
      chk("rnd_err", err_pulse, ee);
      chk("rnd_ucc", uc_changed, eu);
      chk("rnd_locked", locked, m_locked);
      chk("rnd_fail", fail_count, m_fails);
      chk("rnd_prog", prog_mode, m_mode != 0);
      chk("rnd_lockout", lockout, m_lockout);
      if (m_lockout) begin
        wait_lockout(1'b0, n);
        m_lockout = 0;
        m_fails   = 0;
        chk("rnd_lk_len", n, LCY);
        chk("rnd_lk_fail", fail_count, 0);
        chk("rnd_lk_cnt", digit_count, 0);
      end else begin
        @(negedge hwclk);
        chk("rnd_pulse_end", {ok_pulse, err_pulse, uc_changed}, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/keylock_core.md
# keylock_core

Parametrised keypad lock controller that replaces the fixed 6-digit lock datapath and control. It consumes one-cycle debounced key strobes from the keypad scanner, assembles BCD codes of configurable length, and checks them against a user code (UC) and a fixed master code (PC). It supports UC reprogramming with confirmation and adds a failed-attempt counter with timed lockout. It drives the lock state and status pulses consumed by the LED pattern and serial sender blocks.

## Interface
- DIGITS, 6: code length in BCD digits; codes are 4*DIGITS bits, packed, most significant digit first.
- PC, 24'h555116: master code, 4*DIGITS bits.
- UC_INIT, 24'h666666: UC value after reset.
- MAX_FAILS, 3: consecutive failures that trigger lockout (>=1).
- LOCKOUT_CYCLES, 24000000: lockout duration in hwclk cycles (>=1).
- CW = $clog2(DIGITS+1), FW = $clog2(MAX_FAILS+1): derived widths, not overridden.

Ports:
- hwclk  in  1  system clock (12 MHz).
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key is sampled only when high.
- key  in  4  0-9 digit; 10 '*' clear; 11 '#' enter; 12-15 ignored.
- locked  out  1  lock state.
- lockout  out  1  high while keys are being refused after MAX_FAILS failures.
- prog_mode  out  1  high in NEW_UC or CONFIRM_UC.
- ok_pulse  out  1  one cycle: successful unlock, lock, or UC change.
- err_pulse  out  1  one cycle: any rejected '#'.
- uc_changed  out  1  one cycle: UC register updated.
- digit_count  out  CW  digits in the entry buffer, saturating at DIGITS.
- fail_count  out  FW  consecutive failures.

## Operation
- States: IDLE, CHECK, NEW_UC, CHECK_NEW, CONFIRM_UC, CHECK_CONF, LOCKOUT.
- Entry buffer, in IDLE, NEW_UC, and CONFIRM_UC:
  - A digit shifts left 4 bits into the buffer and increments digit_count.
  - Once digit_count reaches DIGITS, further digits set an overflow flag. The buffer is not changed.
  - '*' clears the buffer, digit_count, and overflow.
  - '#' moves to the matching CHECK* state. The buffer, count, and flag clear on exit from CHECK*.
- CHECK, in priority order:
  - Entry is invalid (digit_count != DIGITS or overflow): err_pulse, fail_count+1.
  - buffer == PC: go to NEW_UC. fail_count is cleared. locked is unchanged.
  - buffer == UC: toggle locked, ok_pulse, fail_count cleared.
  - Otherwise: err_pulse, fail_count+1.
  - If the new fail_count equals MAX_FAILS, go to LOCKOUT. Otherwise return to IDLE.
- CHECK_NEW:
  - If the entry is valid and buffer != PC: store the buffer as the candidate and go to CONFIRM_UC.
  - Otherwise: err_pulse and go to IDLE.
- CHECK_CONF:
  - If the entry is valid and buffer == candidate: UC <= candidate, uc_changed and ok_pulse, then IDLE.
  - Otherwise: err_pulse and IDLE; UC is unchanged.
- Programming failures do not increment fail_count.
- LOCKOUT:
  - All keys are ignored.
  - A down-counter is loaded with LOCKOUT_CYCLES-1 on entry.
  - At 0, fail_count clears and the state returns to IDLE.
- Comparisons are full-width equality on 4*DIGITS bits.

## Timing
- Reset values: state IDLE; locked, lockout, prog_mode, and all pulses 0; digit_count 0; fail_count 0; UC = UC_INIT; candidate 0; buffer 0.
- A key strobe at edge n updates the buffer and digit_count at edge n.
- '#' at edge n: CHECK* occupies cycle n..n+1. locked, UC, fail_count, the pulses, lockout, and prog_mode all update at edge n+1, so pulses are high for cycle n+1..n+2.
- key_valid while in any CHECK* or LOCKOUT state is dropped; it is not queued.
- lockout is high for exactly LOCKOUT_CYCLES cycles. The first key accepted after lockout is one strobed at the edge where lockout reads 0.
- Asserting reset mid-entry, mid-programming, or mid-lockout returns every register to its reset value immediately, including UC.
- key values 12-15 are no-ops in every state.

## Test plan
- Unlock/lock: after reset, enter 6,6,6,6,6,6,'#' -> locked=1 and ok_pulse two edges after the '#' strobe. Repeat the sequence -> locked=0.
- Length errors: enter 6,6,6,'#' -> err_pulse, fail_count=1. Enter seven 6s then '#' -> err_pulse, fail_count=2, UC unchanged.
- Lockout (LOCKOUT_CYCLES=50): enter three wrong codes -> lockout=1 for exactly 50 cycles. A valid UC strobed mid-lockout has no effect. After lockout, fail_count=0 and the UC unlocks.
- Reprogram: enter PC, then 1,2,3,4,5,6,'#', then 1,2,3,4,5,6,'#' -> uc_changed, prog_mode falls. Old code 666666 now gives err_pulse; 123456 toggles locked.
- Failed reprogram: enter PC, 111111, 222222 -> err_pulse, UC stays 666666, fail_count unchanged. Entering PC then PC as the new UC -> err_pulse at CHECK_NEW.
- Parametrisation and reset: with DIGITS=4, PC=16'h1234, UC_INIT=16'h0000, enter 0,0,0,0,'#' -> locked=1. Asserting reset during CONFIRM_UC -> all outputs return to reset values within the same cycle.
